// File: rtl/lab2_proc_fetch_inst_queue.sv
// Instruction queue between the imem response port and D; drops wrong-path
// responses after a squash. Optional zero-latency bypass: LAB2_PROC_FETCH_INST_QUEUE_BYPASS_EN.
module lab2_proc_fetch_inst_queue #(
  parameter int p_num_entries     = 2,
  parameter int p_max_outstanding = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             imemreq_fire,
  output logic                             outstanding_full,
  input  logic                             imemresp_val,
  output logic                             imemresp_rdy,
  input  logic [31:0]                      imemresp_data,
  input  logic [31:0]                      imemresp_pc,
  input  logic                             squash,
  output logic                             inst_val_D,
  input  logic                             inst_rdy_D,
  output logic [31:0]                      inst_D,
  output logic [31:0]                      pc_D,
  output logic [$clog2(p_num_entries):0]   num_entries
);

  localparam int AW = $clog2(p_num_entries);
  localparam int CW = $clog2(p_max_outstanding + 1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(p_num_entries);
  localparam logic [CW-1:0] MAX_OUT  = CW'(p_max_outstanding);

  logic [31:0]   inst_q [p_num_entries];
  logic [31:0]   pc_q   [p_num_entries];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [AW:0]   occ_q, occ_d;
  logic [CW-1:0] outst_q, outst_d, drop_q, drop_d;

  logic full, empty, drop_pend, resp_acc, byp, enq, deq;

  always_comb begin
    full      = (occ_q == FULL_CNT);
    empty     = (occ_q == '0);
    drop_pend = (drop_q != '0);
`ifdef LAB2_PROC_FETCH_INST_QUEUE_BYPASS_EN
    byp       = empty & !drop_pend & !squash & imemresp_val;
`else
    byp       = 1'b0;
`endif
    // rdy depends only on registered state, never on inst_rdy_D
    imemresp_rdy     = drop_pend | !full;
    resp_acc         = imemresp_val & imemresp_rdy;
    inst_val_D       = (!empty & !squash) | byp;
    outstanding_full = (outst_q == MAX_OUT);
    num_entries      = occ_q;
`ifdef LAB2_PROC_FETCH_INST_QUEUE_BYPASS_EN
    inst_D = byp ? imemresp_data : inst_q[head_q];
    pc_D   = byp ? imemresp_pc   : pc_q[head_q];
`else
    inst_D = inst_q[head_q];
    pc_D   = pc_q[head_q];
`endif
    deq = !empty & !squash & inst_rdy_D;
    enq = resp_acc & !drop_pend & !squash & !(byp & inst_rdy_D);

    outst_d = outst_q + CW'(imemreq_fire) - CW'(resp_acc);
    if (squash) begin
      // everything still in flight after this cycle is wrong-path
      drop_d = outst_d;
      head_d = '0;
      tail_d = '0;
      occ_d  = '0;
    end else begin
      drop_d = drop_q - CW'(resp_acc & drop_pend);
      head_d = head_q + AW'(deq);
      tail_d = tail_q + AW'(enq);
      occ_d  = occ_q + (AW+1)'(enq) - (AW+1)'(deq);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      occ_q   <= '0;
      outst_q <= '0;
      drop_q  <= '0;
      for (int i = 0; i < p_num_entries; i++) begin
        inst_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      occ_q   <= occ_d;
      outst_q <= outst_d;
      drop_q  <= drop_d;
      if (enq) begin
        inst_q[tail_q] <= imemresp_data;
        pc_q[tail_q]   <= imemresp_pc;
      end
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!reset) begin
      assert (!(imemreq_fire && outstanding_full));
      assert (!(resp_acc && (outst_q == '0)));
    end
  end
`endif

endmodule
